// File: rtl/spi_flash_slave.sv
// SPI flash-style read slave: accepts 0x03 + 24-bit byte address, then streams
// bytes fetched one 32-bit word at a time from a synchronous memory port.
`timescale 1ns/1ps

module spi_flash_slave (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_clk,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        mem_ren,
   output logic [21:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        cmd_err
);

   localparam logic [7:0] CMD_READ = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      FETCH,
      DATA,
      IGNORE
   } state_t;

   // Bit order of the synchronizer bank: 0 = spi_clk, 1 = spi_cs, 2 = spi_mosi
   logic [2:0] sync_in;
   logic [2:0] sync_out;

   assign sync_in = {spi_mosi, spi_cs, spi_clk};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         localparam logic IDLE_LVL = (gi == 1);
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               meta_reg <= IDLE_LVL;
               sync_reg <= IDLE_LVL;
            end else begin
               meta_reg <= sync_in[gi];
               sync_reg <= meta_reg;
            end
         end

         assign sync_out[gi] = sync_reg;
      end
   endgenerate

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   logic sclk_prev_reg;
   logic cs_prev_reg;
   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;

   assign sclk_s    = sync_out[0];
   assign cs_s      = sync_out[1];
   assign mosi_s    = sync_out[2];
   assign sclk_rise = sclk_s & ~sclk_prev_reg;
   assign sclk_fall = ~sclk_s & sclk_prev_reg;
   assign cs_rise   = cs_s & ~cs_prev_reg;
   assign cs_fall   = ~cs_s & cs_prev_reg;

   state_t      state_reg,      state_next;
   logic [4:0]  bit_cnt_reg,    bit_cnt_next;
   logic [23:0] in_shift_reg,   in_shift_next;
   logic [23:0] byte_addr_reg,  byte_addr_next;
   logic [7:0]  out_shift_reg,  out_shift_next;
   logic        miso_reg,       miso_next;
   logic        fetch_wait_reg, fetch_wait_next;
   logic        cmd_err_reg,    cmd_err_next;
   logic [23:0] in_shifted;

   assign in_shifted = {in_shift_reg[22:0], mosi_s};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_prev_reg  <= 1'b0;
         cs_prev_reg    <= 1'b1;
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         in_shift_reg   <= '0;
         byte_addr_reg  <= '0;
         out_shift_reg  <= '0;
         miso_reg       <= 1'b0;
         fetch_wait_reg <= 1'b0;
         cmd_err_reg    <= 1'b0;
      end else begin
         sclk_prev_reg  <= sclk_s;
         cs_prev_reg    <= cs_s;
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         in_shift_reg   <= in_shift_next;
         byte_addr_reg  <= byte_addr_next;
         out_shift_reg  <= out_shift_next;
         miso_reg       <= miso_next;
         fetch_wait_reg <= fetch_wait_next;
         cmd_err_reg    <= cmd_err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      in_shift_next   = in_shift_reg;
      byte_addr_next  = byte_addr_reg;
      out_shift_next  = out_shift_reg;
      miso_next       = miso_reg;
      fetch_wait_next = fetch_wait_reg;
      cmd_err_next    = 1'b0;

      // Deselect beats any clock edge seen in the same cycle
      if (cs_rise) begin
         state_next      = IDLE;
         bit_cnt_next    = '0;
         miso_next       = 1'b0;
         fetch_wait_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               miso_next = 1'b0;
               if (cs_fall) begin
                  state_next    = CMD;
                  bit_cnt_next  = '0;
                  in_shift_next = '0;
               end
            end

            CMD: begin
               if (sclk_rise) begin
                  in_shift_next = in_shifted;
                  if (bit_cnt_reg == 5'd7) begin
                     bit_cnt_next = '0;
                     if (in_shifted[7:0] == CMD_READ) begin
                        state_next = ADDR;
                     end else begin
                        state_next   = IGNORE;
                        cmd_err_next = 1'b1;
                     end
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 5'd1;
                  end
               end
            end

            ADDR: begin
               if (sclk_rise) begin
                  in_shift_next = in_shifted;
                  if (bit_cnt_reg == 5'd23) begin
                     bit_cnt_next    = '0;
                     byte_addr_next  = in_shifted;
                     fetch_wait_next = 1'b0;
                     state_next      = FETCH;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 5'd1;
                  end
               end
            end

            // First cycle issues the read, second captures the addressed byte
            FETCH: begin
               if (!fetch_wait_reg) begin
                  fetch_wait_next = 1'b1;
               end else begin
                  out_shift_next  = mem_rdata[{byte_addr_reg[1:0], 3'b000} +: 8];
                  fetch_wait_next = 1'b0;
                  bit_cnt_next    = '0;
                  state_next      = DATA;
               end
            end

            DATA: begin
               if (sclk_fall) begin
                  miso_next      = out_shift_reg[7];
                  out_shift_next = {out_shift_reg[6:0], 1'b0};
               end
               if (sclk_rise) begin
                  if (bit_cnt_reg == 5'd7) begin
                     bit_cnt_next    = '0;
                     byte_addr_next  = byte_addr_reg + 24'd1;
                     fetch_wait_next = 1'b0;
                     state_next      = FETCH;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 5'd1;
                  end
               end
            end

            IGNORE: begin
               miso_next = 1'b0;
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign spi_miso = miso_reg;
   assign mem_ren  = (state_reg == FETCH) && !fetch_wait_reg;
   assign mem_addr = byte_addr_reg[23:2];
   assign busy     = (state_reg != IDLE);
   assign cmd_err  = cmd_err_reg;

endmodule

// File: doc/spi_flash_slave.md
SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Port: clk  input  1  system clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: spi_clk  input  1  SPI serial clock from master, CPOL=0, asynchronous to clk.
REQ-005 Port: spi_cs  input  1  chip select, active-low.
REQ-006 Port: spi_mosi  input  1  serial command/address from master, MSB first.
REQ-007 Port: spi_miso  output  1  serial read data to master, MSB first.
REQ-008 Port: mem_ren  output  1  one-cycle word read strobe.
REQ-009 Port: mem_addr  output  22  word address (byte address [23:2]).
REQ-010 Port: mem_rdata  input  32  read word, valid exactly 1 clk after mem_ren.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: cmd_err  output  1  one-cycle pulse on unsupported command.

Function
REQ-013 SHALL pass spi_clk, spi_cs, spi_mosi through 2-flop synchronizers; edges detected from synchronized spi_clk vs. its previous value.
REQ-014 SHALL sample spi_mosi on spi_clk rising edges and update spi_miso on falling edges (master transmits on negedge, samples on posedge).
REQ-015 Operating constraint: clk frequency >= 8x spi_clk frequency; behaviour outside this is undefined.
REQ-016 States: IDLE, CMD, ADDR, FETCH, DATA, IGNORE.
REQ-017 IDLE -> CMD on synchronized spi_cs falling; bit counter cleared.
REQ-018 CMD: shift 8 bits; after 8th rising edge, 0x03 -> ADDR, any other value -> IGNORE with cmd_err pulsed one cycle.
REQ-019 ADDR: shift 24 bits into byte address; after 24th rising edge -> FETCH.
REQ-020 FETCH: assert mem_ren one cycle with mem_addr = byte_addr[23:2]; next cycle load shift register with byte byte_addr[1:0] of mem_rdata (byte 0 = bits [7:0], little-endian) -> DATA.
REQ-021 DATA: on each falling edge drive next bit MSB first; after 8th rising edge of a byte, byte_addr increments by 1 and state -> FETCH for next byte.
REQ-022 Byte address SHALL wrap 0xFFFFFF -> 0x000000 without error.
REQ-023 First data bit SHALL appear on spi_miso at the first falling edge after the 32nd rising edge.
REQ-024 spi_miso SHALL be 0 in IDLE, CMD, ADDR, IGNORE and FETCH-before-first-byte.
REQ-025 IGNORE: discard all bits until spi_cs deasserts.
REQ-026 Synchronized spi_cs rising in any state SHALL return to IDLE next cycle, abandoning any partial byte; a pending mem_rdata is discarded.
REQ-027 spi_cs rise and spi_clk edge in the same cycle: cs rise wins, edge ignored.
REQ-028 mem_ren SHALL never be asserted outside FETCH and at most once per FETCH entry.

Reset
REQ-029 Reset SHALL force state IDLE, counters and shift registers 0, spi_miso=0, mem_ren=0, mem_addr=0, busy=0, cmd_err=0, synchronizer flops to idle levels (spi_clk=0, spi_cs=1).
REQ-030 Reset asserted mid-transaction SHALL abort it; after release the block waits for a fresh spi_cs falling edge.

Verification
REQ-031 Read: cs low, send 0x03 + addr 0x000004, memory word 1 = 0x44332211, 32 data clocks -> miso bytes 0x11,0x22,0x33,0x44; mem_ren pulses 4 times at mem_addr 1.
REQ-032 Unaligned/word-crossing: addr 0x000007, 16 data clocks, word1=0x44332211, word2=0x88776655 -> miso 0x44 then 0x55.
REQ-033 Wrap: addr 0xFFFFFF, 16 data clocks -> second fetch mem_addr 0x000000, byte 0 of word 0 returned.
REQ-034 Bad command 0x9F -> cmd_err one-cycle pulse, no mem_ren, miso 0 until cs high, busy drops after cs rise.
REQ-035 Abort: cs high after 4 data bits, then new read of addr 0x000000 -> second transaction correct, no leftover bits.
REQ-036 Reset asserted during DATA -> all outputs at reset values within the asserting cycle; subsequent read correct.
